// File: rtl/a7_ddr3_pkg.sv
// Shared encodings for the DDR3 read/write arbiter: FSM states, MIG command
// codes and the default application-address width.
package a7_ddr3_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } arb_state_t;

  localparam logic [2:0] MIG_CMD_WR = 3'b000;
  localparam logic [2:0] MIG_CMD_RD = 3'b001;

  localparam int AW_DEFAULT = 28;

endpackage

// File: rtl/a7_ddr3_arbit.sv
// Arbitrates the MIG app command bus between a write and a read controller,
// alternating on contention and forcing release of grants that run too long.
module a7_ddr3_arbit
  import a7_ddr3_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int AW          = AW_DEFAULT
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          init_calib_complete,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          wr_end,
  input  logic          rd_end,
  output logic          wr_cmd_start,
  output logic          rd_cmd_start,
  input  logic          wr_app_en,
  input  logic [AW-1:0] wr_app_addr,
  input  logic [2:0]    wr_app_cmd,
  input  logic          rd_app_en,
  input  logic [AW-1:0] rd_app_addr,
  input  logic [2:0]    rd_app_cmd,
  output logic          app_en,
  output logic [AW-1:0] app_addr,
  output logic [2:0]    app_cmd,
  output logic [1:0]    arb_state,
  output logic          timeout_err
);

  // Wide enough to hold TIMEOUT_CYC itself after the final increment.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t    state, next_state;
  logic          last_rd;
  logic [CW-1:0] cnt;
  logic          to_hit;
  logic          grant_entry;

  assign to_hit      = (cnt == CW'(TIMEOUT_CYC - 1));
  assign grant_entry = (state == ST_IDLE) &&
                       ((next_state == ST_WRITE) || (next_state == ST_READ));
  assign arb_state   = state;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      last_rd      <= 1'b1;
      cnt          <= '0;
      timeout_err  <= 1'b0;
      wr_cmd_start <= 1'b0;
      rd_cmd_start <= 1'b0;
    end else begin
      state        <= next_state;
      wr_cmd_start <= grant_entry && (next_state == ST_WRITE);
      rd_cmd_start <= grant_entry && (next_state == ST_READ);
      if (grant_entry) begin
        cnt     <= '0;
        last_rd <= (next_state == ST_READ);
      end else if ((state == ST_WRITE) || (state == ST_READ)) begin
        cnt <= cnt + 1'b1;
      end
      // An end pulse on the timeout cycle is a clean finish, not an error.
      if (to_hit && (((state == ST_WRITE) && !wr_end) ||
                     ((state == ST_READ)  && !rd_end)))
        timeout_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:  if (init_calib_complete) next_state = ST_IDLE;
      ST_IDLE: begin
        if (!init_calib_complete)              next_state = ST_INIT;
        else if (wr_req && (!rd_req || last_rd)) next_state = ST_WRITE;
        else if (rd_req)                       next_state = ST_READ;
      end
      ST_WRITE: if (wr_end || to_hit) next_state = ST_IDLE;
      ST_READ:  if (rd_end || to_hit) next_state = ST_IDLE;
      default:  next_state = ST_INIT;
    endcase
  end

  always_comb begin
    app_en   = 1'b0;
    app_addr = '0;
    app_cmd  = '0;
    case (state)
      ST_WRITE: begin
        app_en   = wr_app_en;
        app_addr = wr_app_addr;
        app_cmd  = wr_app_cmd;
      end
      ST_READ: begin
        app_en   = rd_app_en;
        app_addr = rd_app_addr;
        app_cmd  = rd_app_cmd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_a7_ddr3_arbit.sv
// Randomized scoreboard bench for a7_ddr3_arbit: a grant-level reference
// model queues the expected outputs of every cycle, a monitor compares them.
module tb_a7_ddr3_arbit;

  localparam int AW = 28;
  localparam int TO = 16;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cal = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
  logic          wr_cmd_start, rd_cmd_start;
  logic          wr_app_en = 1'b0, rd_app_en = 1'b0;
  logic [AW-1:0] wr_app_addr = '0, rd_app_addr = '0;
  logic [2:0]    wr_app_cmd = '0, rd_app_cmd = '0;
  logic          app_en;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [1:0]    arb_state;
  logic          timeout_err;

  a7_ddr3_arbit #(.TIMEOUT_CYC(TO), .AW(AW)) dut (
    .sclk(sclk), .rst_n(rst_n), .init_calib_complete(cal),
    .wr_req(wr_req), .rd_req(rd_req), .wr_end(wr_end), .rd_end(rd_end),
    .wr_cmd_start(wr_cmd_start), .rd_cmd_start(rd_cmd_start),
    .wr_app_en(wr_app_en), .wr_app_addr(wr_app_addr), .wr_app_cmd(wr_app_cmd),
    .rd_app_en(rd_app_en), .rd_app_addr(rd_app_addr), .rd_app_cmd(rd_app_cmd),
    .app_en(app_en), .app_addr(app_addr), .app_cmd(app_cmd),
    .arb_state(arb_state), .timeout_err(timeout_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [1:0]    st;
    logic          ws, rs, terr, en;
    logic [AW-1:0] addr;
    logic [2:0]    cmd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: who owns the bus, how long the grant has lasted,
  // and whose turn it is on a tie. States: 0 none/uncal, 1 idle, 2 W, 3 R.
  int m_st = 0;
  bit m_turn_wr = 1'b1;
  int m_age = 0;
  bit m_terr = 1'b0;
  bit m_ws = 1'b0, m_rs = 1'b0;

  always @(posedge sclk) begin
    exp_t e;
    bit   fin;
    if (!rst_n) begin
      m_st = 0; m_turn_wr = 1'b1; m_age = 0; m_terr = 1'b0; m_ws = 0; m_rs = 0;
    end else begin
      m_ws = 0; m_rs = 0;
      if (m_st == 0) begin
        if (cal) m_st = 1;
      end else if (m_st == 1) begin
        if (!cal) m_st = 0;
        else if (wr_req && (!rd_req || m_turn_wr)) begin
          m_st = 2; m_ws = 1; m_age = 1; m_turn_wr = 1'b0;
        end else if (rd_req) begin
          m_st = 3; m_rs = 1; m_age = 1; m_turn_wr = 1'b1;
        end
      end else begin
        fin = (m_st == 2) ? wr_end : rd_end;
        if (fin) m_st = 1;
        else if (m_age == TO) begin m_st = 1; m_terr = 1'b1; end
        else m_age++;
      end
    end
    e.st = 2'(m_st); e.ws = m_ws; e.rs = m_rs; e.terr = m_terr;
    e.en = 1'b0; e.addr = '0; e.cmd = '0;
    if (m_st == 2) begin e.en = wr_app_en; e.addr = wr_app_addr; e.cmd = wr_app_cmd; end
    if (m_st == 3) begin e.en = rd_app_en; e.addr = rd_app_addr; e.cmd = rd_app_cmd; end
    exp_q.push_back(e);
  end

  always @(posedge sclk) begin
    exp_t e;
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL t=%0t scoreboard: no expected entry queued", $time);
    end else begin
      e = exp_q.pop_front();
      if (arb_state !== e.st || wr_cmd_start !== e.ws || rd_cmd_start !== e.rs ||
          timeout_err !== e.terr || app_en !== e.en || app_addr !== e.addr ||
          app_cmd !== e.cmd) begin
        n_bad++;
        $display("FAIL t=%0t cycle_outputs: got st=%0d ws=%b rs=%b terr=%b en=%b addr=%h cmd=%0d want st=%0d ws=%b rs=%b terr=%b en=%b addr=%h cmd=%0d",
                 $time, arb_state, wr_cmd_start, rd_cmd_start, timeout_err, app_en, app_addr, app_cmd,
                 e.st, e.ws, e.rs, e.terr, e.en, e.addr, e.cmd);
      end
    end
  end

  // Controller emulation: end pulse `lat` cycles into a grant (0 = never).
  int lat = 5;
  bit spur = 1'b0;
  bit fixed_app = 1'b0;
  int g = 0;

  task automatic step();
    @(negedge sclk);
    if (m_ws || m_rs) g = 1; else if (m_st >= 2) g++;
    wr_end = (m_st == 2) && (lat > 0) && (g == lat);
    rd_end = (m_st == 3) && (lat > 0) && (g == lat);
    if (spur && $urandom_range(3) == 0) begin
      if (m_st == 2) rd_end = 1'b1;
      else if (m_st == 3) wr_end = 1'b1;
    end
    if (fixed_app) begin
      wr_app_en = 1'b1; wr_app_addr = 28'h0000100; wr_app_cmd = 3'b000;
      rd_app_en = 1'b1; rd_app_addr = 28'h0000200; rd_app_cmd = 3'b001;
    end else begin
      wr_app_en = 1'($urandom); wr_app_addr = AW'($urandom); wr_app_cmd = 3'($urandom);
      rd_app_en = 1'($urandom); rd_app_addr = AW'($urandom); rd_app_cmd = 3'($urandom);
    end
  endtask

  initial begin
    // Uncalibrated: held in INIT despite a write request.
    wr_req = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (50) step();
    cal = 1'b1; fixed_app = 1'b1; lat = 12;
    repeat (30) step();
    // Contention: grants must alternate.
    rd_req = 1'b1; lat = 10; spur = 1'b1;
    repeat (60) step();
    // Read only, never ended: repeated timeouts.
    wr_req = 1'b0; lat = 0; spur = 1'b0; fixed_app = 1'b0;
    repeat (45) step();
    // Reset pulse in the middle of a write grant.
    rd_req = 1'b0; wr_req = 1'b1; lat = 8;
    while (m_st != 2) step();
    step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (20) step();
    // Random mix including end-on-timeout-cycle, calibration loss and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 8 == 0) begin
        wr_req = 1'($urandom); rd_req = 1'($urandom);
        lat = $urandom_range(TO + 4); spur = 1'($urandom);
      end
      cal   = ($urandom_range(39) != 0);
      rst_n = ($urandom_range(199) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
